// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - state_e   : multdiv sequencer state encoding (IDLE=0, MD_RUN=1, MD_DONE=2)
//   - NOP_INSTR : instruction word loaded into a latch when it is bubbled/flushed
//   - REG_ZERO  : hard-wired zero register; writes to it never create hazards
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-status inputs and latch-control outputs of the hazard
// controller.
//   master : pipeline side (drives status, consumes enables/bubbles/starts)
//   slave  : hazard controller
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
);
  // Pipeline status
  logic             dx_is_mult;
  logic             dx_is_div;
  logic             dx_is_load;
  logic [REG_W-1:0] dx_rd;
  logic [REG_W-1:0] fd_rs;
  logic [REG_W-1:0] fd_rt;
  logic             fd_uses_rs;
  logic             fd_uses_rt;
  logic             xm_redirect;
  logic             md_ready;
  // Latch control and multdiv sequencing
  logic              pc_en;
  logic              fd_en;
  logic              dx_en;
  logic              fd_flush;
  logic              dx_bubble;
  logic              xm_bubble;
  logic              md_start_mult;
  logic              md_start_div;
  logic              md_result_valid;
  logic              md_timeout;
  logic              md_busy;
  logic [PERF_W-1:0] perf_stall_cycles;

  modport master (
    output dx_is_mult, dx_is_div, dx_is_load, dx_rd, fd_rs, fd_rt,
           fd_uses_rs, fd_uses_rt, xm_redirect, md_ready,
    input  pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble,
           md_start_mult, md_start_div, md_result_valid, md_timeout,
           md_busy, perf_stall_cycles
  );

  modport slave (
    input  dx_is_mult, dx_is_div, dx_is_load, dx_rd, fd_rs, fd_rt,
           fd_uses_rs, fd_uses_rt, xm_redirect, md_ready,
    output pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble,
           md_start_mult, md_start_div, md_result_valid, md_timeout,
           md_busy, perf_stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector.
//   dx_is_load, dx_rd : load in D/X and its destination
//   fd_rs/fd_rt       : F/D source specifiers, qualified by fd_uses_rs/rt
//   hazard            : F/D needs a value the D/X load has not produced yet
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             dx_is_load,
  input  logic [REG_W-1:0] dx_rd,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  output logic             hazard
);
  logic rd_live;

  // A load to the zero register produces nothing a consumer can depend on.
  assign rd_live = (dx_rd != REG_W'(REG_ZERO));

  assign hazard = dx_is_load && rd_live &&
                  ((fd_uses_rs && (fd_rs == dx_rd)) ||
                   (fd_uses_rt && (fd_rt == dx_rd)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   clock, reset : master clock, synchronous active-high reset
//   hz (slave)   : pipeline status in; PC/latch enables, bubbles, multdiv
//                  start pulses, result/timeout flags and stall counter out
// Redirects from X/M flush the front end; multdiv ops freeze the front end
// while the unit runs (bounded by MD_TIMEOUT); load-use costs one stall.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int REG_W      = 5,
  parameter int PERF_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_e            state;
  logic [CNT_W-1:0]  md_cnt;
  logic              md_timeout_q;
  logic [PERF_W-1:0] perf_q;
  logic              load_use;
  logic              md_op;

  logic pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble;
  logic start_mult, start_div, result_valid, busy;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .dx_is_load (hz.dx_is_load),
    .dx_rd      (hz.dx_rd),
    .fd_rs      (hz.fd_rs),
    .fd_rt      (hz.fd_rt),
    .fd_uses_rs (hz.fd_uses_rs),
    .fd_uses_rt (hz.fd_uses_rt),
    .hazard     (load_use)
  );

  assign md_op = hz.dx_is_mult | hz.dx_is_div;

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    pc_en        = 1'b1;
    fd_en        = 1'b1;
    dx_en        = 1'b1;
    fd_flush     = 1'b0;
    dx_bubble    = 1'b0;
    xm_bubble    = 1'b0;
    start_mult   = 1'b0;
    start_div    = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (hz.xm_redirect) begin
            // Wrong-path instructions in F/D and D/X are squashed.
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end else if (md_op) begin
            start_mult = hz.dx_is_mult;
            start_div  = hz.dx_is_div & ~hz.dx_is_mult;
            pc_en      = 1'b0;
            fd_en      = 1'b0;
            dx_en      = 1'b0;
            xm_bubble  = 1'b1;
          end else if (load_use) begin
            // The bubble removes the load's consumer from D/X next cycle,
            // so this stall lasts exactly one cycle.
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_bubble = 1'b1;
          end
        end
        MD_RUN: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_en     = 1'b0;
          xm_bubble = 1'b1;
          busy      = 1'b1;
        end
        MD_DONE: result_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      md_cnt       <= '0;
      md_timeout_q <= 1'b0;
      perf_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!hz.xm_redirect && md_op) begin
            state  <= MD_RUN;
            md_cnt <= '0;
          end
        end
        MD_RUN: begin
          md_cnt <= md_cnt + 1'b1;
          if (hz.md_ready) begin
            state        <= MD_DONE;
            md_timeout_q <= 1'b0;
          end else if (md_cnt == CNT_LAST) begin
            state        <= MD_DONE;
            md_timeout_q <= 1'b1;
          end
        end
        MD_DONE: begin
          state        <= IDLE;
          md_timeout_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (!pc_en && (perf_q != {PERF_W{1'b1}}))
        perf_q <= perf_q + 1'b1;
    end
  end

  assign hz.pc_en             = pc_en;
  assign hz.fd_en             = fd_en;
  assign hz.dx_en             = dx_en;
  assign hz.fd_flush          = fd_flush;
  assign hz.dx_bubble         = dx_bubble;
  assign hz.xm_bubble         = xm_bubble;
  assign hz.md_start_mult     = start_mult;
  assign hz.md_start_div      = start_div;
  assign hz.md_result_valid   = result_valid;
  assign hz.md_timeout        = md_timeout_q;
  assign hz.md_busy           = busy;
  assign hz.perf_stall_cycles = perf_q;
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (PC, F/D, D/X, X/M, M/W latches).
- Detects load-use hazards and resolves taken branches/jumps from X/M.
- Sequences the multi-cycle multdiv unit: issues its start pulse, freezes the front end until the result is ready, and supervises with a timeout.
- Drives the enable and bubble inputs of the PC and pipeline latch registers.

Parameters:
- MD_TIMEOUT, 40, max cycles spent in MD_RUN before forced completion (≥2).
- REG_W, 5, register specifier width.
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- clock  in  1  master clock.
- reset  in  1  synchronous, active-high.
- dx_is_mult  in  1  D/X holds a mul.
- dx_is_div  in  1  D/X holds a div.
- dx_is_load  in  1  D/X holds lw.
- dx_rd  in  REG_W  D/X destination register.
- fd_rs  in  REG_W  F/D source A.
- fd_rt  in  REG_W  F/D source B.
- fd_uses_rs  in  1  F/D reads rs.
- fd_uses_rt  in  1  F/D reads rt.
- xm_redirect  in  1  branch taken/jump resolved in X/M.
- md_ready  in  1  multdiv result ready.
- pc_en  out  1  PC write enable.
- fd_en  out  1  F/D write enable.
- dx_en  out  1  D/X write enable.
- fd_flush  out  1  load nop into F/D.
- dx_bubble  out  1  load nop into D/X.
- xm_bubble  out  1  load nop into X/M.
- md_start_mult  out  1  one-cycle multdiv start, mult.
- md_start_div  out  1  one-cycle multdiv start, div.
- md_result_valid  out  1  multdiv result may be latched into X/M this cycle.
- md_timeout  out  1  result invalid; completion was forced by timeout.
- md_busy  out  1  state is MD_RUN.
- perf_stall_cycles  out  PERF_W  count of cycles with pc_en=0.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset:
  - state=IDLE, cycle counter=0, md_timeout=0, perf_stall_cycles=0.
  - While reset is high: pc_en=fd_en=dx_en=1, all flush/bubble/start outputs 0, md_busy=0, md_result_valid=0.
- Default (no hazard): all enables 1; flush, bubble and start outputs 0.
- FSM states: IDLE, MD_RUN, MD_DONE.
- IDLE, evaluated in priority order:
  1. xm_redirect: fd_flush=1, dx_bubble=1, pc_en=1. No multdiv start and no load-use stall. Stay IDLE.
  2. dx_is_mult|dx_is_div:
     - Assert md_start_mult=dx_is_mult and md_start_div=dx_is_div&~dx_is_mult (mult wins if both are set).
     - pc_en=fd_en=dx_en=0, xm_bubble=1.
     - Next state MD_RUN, counter cleared to 0.
  3. Load-use: dx_is_load, dx_rd≠0, and ((fd_uses_rs & fd_rs==dx_rd) | (fd_uses_rt & fd_rt==dx_rd)). Then pc_en=fd_en=0, dx_bubble=1. Exactly one stall cycle per hazard.
- MD_RUN:
  - pc_en=fd_en=dx_en=0, xm_bubble=1, md_busy=1, counter increments each cycle.
  - md_ready=1 → MD_DONE, md_timeout←0.
  - Else if counter==MD_TIMEOUT-1 → MD_DONE, md_timeout←1.
  - xm_redirect and load-use are ignored; X/M holds a bubble, so neither can legally occur.
- MD_DONE (exactly 1 cycle):
  - md_result_valid=1, all enables 1, no bubbles; the multdiv instruction advances into X/M.
  - Next state IDLE.
  - md_timeout holds its value during MD_DONE and clears on return to IDLE.
- Back-to-back multdiv: the next instruction reaches D/X in the IDLE cycle following MD_DONE and starts then. Minimum total latency = 3 cycles (IDLE start, ≥1 MD_RUN, MD_DONE).
- md_ready is ignored outside MD_RUN.
- md_start_* are combinational and high in exactly one cycle per multdiv instruction. The multdiv unit latches operands at that edge.
- perf_stall_cycles increments on every non-reset cycle with pc_en=0 and saturates at all-ones.
- Reset mid-MD_RUN: return to IDLE next edge; no md_result_valid is produced.

Decomposition:
- Shared package holds:
  - FSM state encoding (2 bits: IDLE=0, MD_RUN=1, MD_DONE=2).
  - The NOP instruction constant (32'h0).
  - The register-zero constant.
- One natural sub-module: `load_use_detect` (purely combinational compare). The FSM, counter and perf counter stay in the top.

Test Plan:
- Load-use: lw r3 in D/X, add r4,r3,r1 in F/D → one cycle of pc_en=0, fd_en=0, dx_bubble=1, then all enables 1. perf_stall_cycles=1.
- Load to r0: lw r0 in D/X, F/D reads r0 → no stall.
- Multdiv, normal completion: mul in D/X, md_ready after 17 MD_RUN cycles → md_start_mult for 1 cycle, md_busy for 17 cycles, md_result_valid for 1 cycle, md_timeout=0. perf_stall_cycles=18.
- Multdiv timeout: div, md_ready never asserted, MD_TIMEOUT=40 → 40 MD_RUN cycles, then MD_DONE with md_timeout=1 and md_result_valid=1.
- Redirect priority: xm_redirect=1 with mul in D/X → fd_flush=1 and dx_bubble=1, no md_start_*, state stays IDLE.
- Reset mid-run: reset asserted on MD_RUN cycle 5 → next cycle IDLE, md_busy=0, counter=0, perf_stall_cycles=0, and md_ready arriving afterwards is ignored.
